programmable_clock_divider: RTL
===============================

# programmable_clock_divider

Multi-channel, runtime-programmable clock divider for the processor's slow-clock and LED/display-refresh domains. Each channel divides `clock_in` by its own divisor and produces a divided square wave plus a one-cycle tick. New divisors can be written at any time and take effect only at a period boundary, so divided outputs never glitch or produce short pulses. Sits at the top level, fed directly from the board oscillator.

## Interface
- `NUM_CHANNELS`, 4 — number of independent divider channels (1..16).
- `DIV_WIDTH`, 28 — width of counters and divisors.
- `RESET_DIVISOR`, 250000000 — active divisor of every channel after reset.
- `clock_in`  in  1  sole clock; everything samples on its rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `cfg_wr_en`  in  1  divisor write strobe, one write per cycle.
- `cfg_chan`  in  CHAN_W = max(1, clog2(NUM_CHANNELS))  target channel; writes with index ≥ NUM_CHANNELS are ignored.
- `cfg_divisor`  in  DIV_WIDTH  new divisor value.
- `chan_enable`  in  NUM_CHANNELS  per-channel run enable.
- `div_pending`  out  NUM_CHANNELS  channel has a written divisor that is not yet active.
- `clock_out`  out  NUM_CHANNELS  divided clock, registered.
- `tick_out`  out  NUM_CHANNELS  one-cycle pulse in the last cycle of each period, registered.

## Operation
Per-channel state: `count`, `active_div`, `shadow_div`, `pending`.
- Reset: `count`=0, `active_div`=RESET_DIVISOR, `shadow_div`=0, `pending`=0. `clock_out`, `tick_out` and `div_pending` are all 0.
- Channel modes, decoded from `active_div`:
  - STOP (D=0): `count` held at 0; `clock_out`=0; `tick_out`=0.
  - FAST (D=1): `count` held at 0; `clock_out`=1; `tick_out`=1 every enabled cycle.
  - RUN (D≥2):
    - When enabled, `count` increments each cycle.
    - When `count` ≥ D−1, `count` wraps to 0. The ≥ is a guard only; `count` never exceeds D−1 in normal operation.
    - `clock_out` = (`count` ≥ D>>1). Low for floor(D/2) cycles, then high for ceil(D/2) cycles.
    - `tick_out` = enabled AND (`count` == D−1).
- Enable low: `count` and `clock_out` hold their values; `tick_out`=0. Re-enabling resumes from the held `count`.
- Divisor write: `shadow_div` ← `cfg_divisor` and `pending` ← 1.
  - A second write while `pending` is set overwrites `shadow_div`. The last write wins.
- Divisor apply: `active_div` ← `shadow_div`, `count` ← 0, `pending` ← 0. This happens on the first of these:
  - the wrap edge in RUN;
  - any edge in STOP or FAST mode;
  - any edge while the channel is disabled.
- Write and apply on the same edge: the apply uses the old shadow value. The new write then sets `pending` again.
- Arithmetic: unsigned, DIV_WIDTH bits. D−1 is computed only in RUN, where D≥2.

## Timing
- All outputs come straight from flops and reflect state in the same cycle. There is no combinational path from inputs to outputs.
- A write at edge k to a disabled or STOP channel makes the new divisor active after edge k+1. `div_pending` is high for exactly one cycle.
- A write at edge k to a RUN channel takes effect at the next wrap. The new period starts with `count`=0 and `clock_out`=0.
- Period in RUN = exactly D enabled cycles.
- `reset` asserted mid-period clears all state immediately, without waiting for a clock edge. Counting restarts on the first edge after deassertion.

## Configuration
- `PROGRAMMABLE_CLOCK_DIVIDER_SYNC_EN` defined:
  - Adds input `sync_in` (1 bit).
  - A high sample restarts every channel at `count`=0 on that edge.
  - Any pending divisor is applied at the same edge, which phase-aligns all channels.
  - `sync_in` has priority over a normal wrap.
  - `tick_out` is 0 on the restart edge's cycle.
- Not defined: no `sync_in` port. Channels run free and align only through reset.

## Structure
- Package `programmable_clock_divider_pkg`:
  - `DIV_STOP`=0 and `DIV_FAST`=1 constants.
  - The channel mode enum {STOP, FAST, RUN}.
  - The default-divisor constant.
- Sub-module `clock_divider_channel`: one channel's counter, shadow/apply logic and output flops. It is instantiated NUM_CHANNELS times by a generate loop. The top level only decodes `cfg_chan`.

## Test plan
- Reset, then write D=4 to ch0 while it is disabled, then enable it → `clock_out[0]` repeats 0,0,1,1; `tick_out[0]` pulses every 4th cycle; `div_pending[0]` high for 1 cycle.
- Write D=5 to ch1 → low 2 cycles, high 3 cycles; tick in the cycle where `count`=4.
- ch0 running with D=6, write D=2 at `count`=1 → the old period completes all 6 cycles, then the output alternates every cycle; no pulse shorter than 1 cycle.
- Write D=0 to a running channel → after the wrap, `clock_out` stays 0 and `tick_out` stays 0. Then write D=1 → `clock_out`=1 and tick every cycle.
- Drop `chan_enable` for 3 cycles mid-period → outputs freeze, no ticks, and the period completes afterwards. Assert `reset` asynchronously mid-period → all outputs 0 immediately.
- With the macro on, run ch0 with D=4 and ch1 with D=8, then pulse `sync_in` → both restart at `count`=0 on the same edge and stay phase-aligned.

Source files
------------

// File: rtl/programmable_clock_divider_pkg.sv
// Shared constants and channel mode type for the programmable clock divider.
// Imported by the channel and top-level modules.
package programmable_clock_divider_pkg;

    localparam int unsigned DIV_STOP        = 0;
    localparam int unsigned DIV_FAST        = 1;
    localparam int          DEFAULT_DIVISOR = 250000000;

    typedef enum logic [1:0] {
        MODE_STOP,
        MODE_FAST,
        MODE_RUN
    } chan_mode_t;

endpackage

// File: rtl/clock_divider_channel.sv
// One divider channel: counter, shadow divisor with boundary-only apply,
// and registered clock/tick outputs.
module clock_divider_channel
    import programmable_clock_divider_pkg::*;
#(
    parameter int DIV_WIDTH     = 28,
    parameter int RESET_DIVISOR = DEFAULT_DIVISOR
) (
    input  logic                 clock_in,
    input  logic                 reset,
    input  logic                 enable,
    input  logic                 restart,
    input  logic                 wr_en,
    input  logic [DIV_WIDTH-1:0] wr_divisor,
    output logic                 pending_out,
    output logic                 clock_out,
    output logic                 tick_out
);

    logic [DIV_WIDTH-1:0] count, active_div, shadow_div;
    logic                 pending;

    logic [DIV_WIDTH-1:0] count_n, active_n;
    logic                 wrap, apply, clk_n, tick_n;
    chan_mode_t           mode, mode_n;

    function automatic chan_mode_t mode_of(input logic [DIV_WIDTH-1:0] d);
        chan_mode_t m;
        m = MODE_RUN;
        unique case (1'b1)
            (d == DIV_WIDTH'(DIV_STOP)): m = MODE_STOP;
            (d == DIV_WIDTH'(DIV_FAST)): m = MODE_FAST;
            default:                     m = MODE_RUN;
        endcase
        return m;
    endfunction

    always_comb begin
        mode    = mode_of(active_div);
        wrap    = 1'b0;
        if (mode == MODE_RUN && enable)
            wrap = (count >= active_div - DIV_WIDTH'(1));
        // Period boundaries are the only safe points to swap divisors
        apply    = pending &&
                   (restart || wrap || mode != MODE_RUN || !enable);
        active_n = apply ? shadow_div : active_div;
        mode_n   = mode_of(active_n);

        if (restart || apply || wrap || mode != MODE_RUN)
            count_n = '0;
        else if (enable)
            count_n = count + DIV_WIDTH'(1);
        else
            count_n = count;

        clk_n  = 1'b0;
        tick_n = 1'b0;
        unique case (mode_n)
            MODE_STOP: begin
                clk_n  = 1'b0;
                tick_n = 1'b0;
            end
            MODE_FAST: begin
                clk_n  = 1'b1;
                tick_n = enable && !restart;
            end
            default: begin
                clk_n  = (count_n >= (active_n >> 1));
                tick_n = enable && !restart &&
                         (count_n == active_n - DIV_WIDTH'(1));
            end
        endcase
    end

    always_ff @(posedge clock_in or posedge reset) begin
        if (reset) begin
            count      <= '0;
            active_div <= DIV_WIDTH'(RESET_DIVISOR);
            shadow_div <= '0;
            pending    <= 1'b0;
            clock_out  <= 1'b0;
            tick_out   <= 1'b0;
        end else begin
            count      <= count_n;
            active_div <= active_n;
            clock_out  <= clk_n;
            tick_out   <= tick_n;
            // A same-edge write re-arms pending after the old shadow applies
            if (wr_en) begin
                shadow_div <= wr_divisor;
                pending    <= 1'b1;
            end else if (apply) begin
                pending    <= 1'b0;
            end
        end
    end

    assign pending_out = pending;

endmodule

// File: rtl/programmable_clock_divider.sv
// Multi-channel runtime-programmable clock divider (top level).
// Optional PROGRAMMABLE_CLOCK_DIVIDER_SYNC_EN adds sync_in phase alignment.
module programmable_clock_divider
    import programmable_clock_divider_pkg::*;
#(
    parameter int NUM_CHANNELS  = 4,
    parameter int DIV_WIDTH     = 28,
    parameter int RESET_DIVISOR = DEFAULT_DIVISOR,
    localparam int CHAN_W = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1
) (
    input  logic                    clock_in,
    input  logic                    reset,
`ifdef PROGRAMMABLE_CLOCK_DIVIDER_SYNC_EN
    input  logic                    sync_in,
`endif
    input  logic                    cfg_wr_en,
    input  logic [CHAN_W-1:0]       cfg_chan,
    input  logic [DIV_WIDTH-1:0]    cfg_divisor,
    input  logic [NUM_CHANNELS-1:0] chan_enable,
    output logic [NUM_CHANNELS-1:0] div_pending,
    output logic [NUM_CHANNELS-1:0] clock_out,
    output logic [NUM_CHANNELS-1:0] tick_out
);

    logic restart;

`ifdef PROGRAMMABLE_CLOCK_DIVIDER_SYNC_EN
    assign restart = sync_in;
`else
    assign restart = 1'b0;
`endif

    for (genvar i = 0; i < NUM_CHANNELS; i++) begin : g_chan
        logic wr_sel;

        assign wr_sel = cfg_wr_en && (cfg_chan == CHAN_W'(i));

        clock_divider_channel #(
            .DIV_WIDTH     (DIV_WIDTH),
            .RESET_DIVISOR (RESET_DIVISOR)
        ) u_chan (
            .clock_in    (clock_in),
            .reset       (reset),
            .enable      (chan_enable[i]),
            .restart     (restart),
            .wr_en       (wr_sel),
            .wr_divisor  (cfg_divisor),
            .pending_out (div_pending[i]),
            .clock_out   (clock_out[i]),
            .tick_out    (tick_out[i])
        );
    end

endmodule
